// File: rtl/fix2half_cyv_if.sv
// Sample stream into the fixed-point to binary16 converter and its result side.
interface fix2half_cyv_if;
    logic        en;
    logic        valid_in;
    logic [31:0] d;
    logic [15:0] q;
    logic        valid_out;
    logic        ovf;
    logic        inexact;

    modport master (output en, valid_in, d, input q, valid_out, ovf, inexact);
    modport slave  (input en, valid_in, d, output q, valid_out, ovf, inexact);
endinterface

// File: rtl/fix2half_cyv.sv
// Signed Qx.FRACBITS fixed point to IEEE binary16, RNE rounding, saturating.
// Three registered stages: magnitude, leading-one search, normalise/round/pack.
module fix2half_cyv #(
    parameter int FRACBITS = 20
) (
    input logic          clk,
    input logic          areset,
    fix2half_cyv_if.slave bus
);
    localparam logic signed [7:0] EOFF = 8'(15 - FRACBITS);

    logic [2:0]  vld_pipe;
    logic        sign1, sign2, zero2;
    logic [31:0] mag1, mag2;
    logic [4:0]  p2, lead;
    logic [15:0] q_r;
    logic        ovf_r, inx_r;

    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 32; i++)
            if (mag1[i]) lead = 5'(i);
    end

    logic signed [7:0] bexp;
    logic        normal, g, st, ovf_c;
    logic [5:0]  sft;
    logic [42:0] shd;
    logic [10:0] m;
    logic [11:0] mr;
    logic [16:0] pack;
    logic [15:0] q_c;
    logic        inx_c;

    // Leading one lands on bit 42 for normals (hidden bit); subnormals use a
    // fixed shift so the field is magnitude * 2^(24-FRACBITS).
    always_comb begin
        bexp   = signed'({3'b0, p2}) + EOFF;
        normal = bexp > 8'sd0;
        sft    = normal ? 6'(p2) + 6'd22 : 6'(FRACBITS + 8);
        shd    = 43'({mag2, 64'b0} >> sft);
        m      = shd[42:32];
        g      = shd[31];
        st     = |shd[30:0];
        mr     = {1'b0, m} + {11'b0, g & (st | m[0])};
        // Exponent field minus one plus the hidden/carry bit of mr yields the
        // final exponent, so mantissa carry-out bumps it for free.
        pack   = normal ? {bexp[6:0] - 7'd1, 10'b0} + {5'b0, mr} : {5'b0, mr};
        ovf_c  = !zero2 && pack >= 17'h07C00;
        q_c    = zero2 ? 16'h0000 : {sign2, ovf_c ? 15'h7BFF : pack[14:0]};
        inx_c  = !zero2 && (g || st || ovf_c);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            vld_pipe <= '0;
            sign1 <= 1'b0; mag1 <= '0;
            sign2 <= 1'b0; mag2 <= '0; p2 <= '0; zero2 <= 1'b0;
            q_r <= '0; ovf_r <= 1'b0; inx_r <= 1'b0;
        end else if (bus.en) begin
            vld_pipe <= {vld_pipe[1:0], bus.valid_in};
            sign1 <= bus.d[31];
            mag1  <= bus.d[31] ? ~bus.d + 32'd1 : bus.d;
            sign2 <= sign1;
            mag2  <= mag1;
            p2    <= lead;
            zero2 <= mag1 == 32'd0;
            q_r   <= q_c;
            ovf_r <= ovf_c;
            inx_r <= inx_c;
        end
    end

    assign bus.q         = q_r;
    assign bus.valid_out = vld_pipe[2];
    assign bus.ovf       = ovf_r;
    assign bus.inexact   = inx_r;
endmodule

// File: tb/tb_fix2half_cyv.sv
// Directed bench: one DUT at FRACBITS=20, one at FRACBITS=0, shared stimulus.
module tb_fix2half_cyv;
    logic clk = 1'b0;
    logic areset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fix2half_cyv_if b20 ();
    fix2half_cyv_if b0 ();

    fix2half_cyv #(.FRACBITS(20)) dut20 (.clk(clk), .areset(areset), .bus(b20));
    fix2half_cyv #(.FRACBITS(0))  dut0  (.clk(clk), .areset(areset), .bus(b0));

    // {d, q, ovf, inexact}
    logic [49:0] vec20 [12] = '{
        {32'h00100000, 16'h3C00, 1'b0, 1'b0},
        {32'hFFF00000, 16'hBC00, 1'b0, 1'b0},
        {32'h80000000, 16'hE800, 1'b0, 1'b0},
        {32'h7FFFFFFF, 16'h6800, 1'b0, 1'b1},
        {32'h00100200, 16'h3C00, 1'b0, 1'b1},
        {32'h00100600, 16'h3C02, 1'b0, 1'b1},
        {32'h00100201, 16'h3C01, 1'b0, 1'b1},
        {32'h00000001, 16'h0010, 1'b0, 1'b0},
        {32'h00000000, 16'h0000, 1'b0, 1'b0},
        {32'h0000003F, 16'h03F0, 1'b0, 1'b0},
        {32'h00000040, 16'h0400, 1'b0, 1'b0},
        {32'hFFFFFFFF, 16'h8010, 1'b0, 1'b0}
    };
    logic [49:0] vec0 [5] = '{
        {32'h00010000, 16'h7BFF, 1'b1, 1'b1},
        {32'hFFFF0000, 16'hFBFF, 1'b1, 1'b1},
        {32'h0000FFE0, 16'h7BFF, 1'b0, 1'b0},
        {32'h0000FFF0, 16'h7BFF, 1'b1, 1'b1},
        {32'h00000001, 16'h3C00, 1'b0, 1'b0}
    };
    logic [15:0] stream_q [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                  16'h4500, 16'h4600, 16'h4700, 16'h4800};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic v, input logic [31:0] din);
        b20.en = e; b20.valid_in = v; b20.d = din;
        b0.en  = e; b0.valid_in  = v; b0.d  = din;
    endtask

    // one valid sample, then bubbles; returns after the third capturing edge
    task automatic apply(input logic [31:0] din);
        @(negedge clk); drive(1'b1, 1'b1, din);
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] prevq;
        logic        preven, prevv;
        int          sent, got;

        drive(1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_q20", 32'(b20.q), 32'h0);
        chk("rst_v20", 32'(b20.valid_out), 32'h0);
        chk("rst_ovf20", 32'(b20.ovf), 32'h0);
        chk("rst_inx20", 32'(b20.inexact), 32'h0);
        chk("rst_q0", 32'(b0.q), 32'h0);
        areset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(vec20[i][49:18]);
            chk($sformatf("f20_v[%0d]", i), 32'(b20.valid_out), 32'h1);
            chk($sformatf("f20_q[%0d]", i), 32'(b20.q), 32'(vec20[i][17:2]));
            chk($sformatf("f20_ovf[%0d]", i), 32'(b20.ovf), 32'(vec20[i][1]));
            chk($sformatf("f20_inx[%0d]", i), 32'(b20.inexact), 32'(vec20[i][0]));
        end
        for (int i = 0; i < 5; i++) begin
            apply(vec0[i][49:18]);
            chk($sformatf("f0_v[%0d]", i), 32'(b0.valid_out), 32'h1);
            chk($sformatf("f0_q[%0d]", i), 32'(b0.q), 32'(vec0[i][17:2]));
            chk($sformatf("f0_ovf[%0d]", i), 32'(b0.ovf), 32'(vec0[i][1]));
            chk($sformatf("f0_inx[%0d]", i), 32'(b0.inexact), 32'(vec0[i][0]));
        end

        // back-to-back stream with en low for two cycles
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        sent = 0; got = 0; preven = 1'b1; prevq = b20.q; prevv = b20.valid_out;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                if (!preven) begin
                    chk($sformatf("hold_q[%0d]", c), 32'(b20.q), 32'(prevq));
                    chk($sformatf("hold_v[%0d]", c), 32'(b20.valid_out), 32'(prevv));
                end else if (b20.valid_out) begin
                    if (got < 8) chk($sformatf("strm_q[%0d]", got), 32'(b20.q), 32'(stream_q[got]));
                    got++;
                end
            end
            prevq = b20.q; prevv = b20.valid_out;
            preven = !(c == 5 || c == 6);
            if (preven && sent < 8) begin
                drive(1'b1, 1'b1, 32'(sent + 1) << 20);
                sent++;
            end else begin
                drive(preven, 1'b0, 32'h0);
            end
            @(negedge clk);
        end
        chk("strm_count", 32'(got), 32'd8);

        // reset with samples in flight
        drive(1'b1, 1'b1, 32'h00100000); @(negedge clk);
        drive(1'b1, 1'b1, 32'h00200000); @(negedge clk);
        drive(1'b1, 1'b1, 32'h00300000); @(negedge clk);
        chk("pre_rst_v", 32'(b20.valid_out), 32'h1);
        areset = 1'b1;
        #1;
        chk("rst_inflight_v", 32'(b20.valid_out), 32'h0);
        chk("rst_inflight_q", 32'(b20.q), 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        areset = 1'b0;
        drive(1'b1, 1'b1, 32'hFFF00000);
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        chk("post_rst_v1", 32'(b20.valid_out), 32'h0);
        @(negedge clk);
        chk("post_rst_v2", 32'(b20.valid_out), 32'h0);
        @(negedge clk);
        chk("post_rst_v3", 32'(b20.valid_out), 32'h1);
        chk("post_rst_q", 32'(b20.q), 32'hBC00);
        @(negedge clk);
        chk("post_rst_v4", 32'(b20.valid_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
